// File: rtl/CPU_package.sv
// Shared CPU datapath types: widths, ALU opcodes and the buffered result record.
package CPU_package;

  localparam int DATA_WIDTH     = 8;
  localparam int REG_ADDR_WIDTH = 3;
  localparam int FLAG_C_BIT     = 0;

  // Encodings 6 and 7 are undefined opcodes.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_INC = 3'd2,
    ALU_DEC = 3'd3,
    ALU_SHL = 3'd4,
    ALU_SHR = 3'd5
  } enum_alu_opcode_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     data;
    logic [REG_ADDR_WIDTH-1:0] dest;
  } alu_result_t;

  function automatic logic op_sets_flags(enum_alu_opcode_t op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_INC, ALU_DEC, ALU_SHL, ALU_SHR: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  function automatic logic op_keeps_carry(enum_alu_opcode_t op);
    return (op == ALU_INC) || (op == ALU_DEC);
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the arithmetic unit, the result stage and the register-file writeback port.
interface alu_result_stage_if;
  import CPU_package::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     in_result;
  logic [1:0]                in_flag;
  enum_alu_opcode_t          in_opcode;
  logic [REG_ADDR_WIDTH-1:0] in_dest;

  logic                      wb_valid;
  logic                      wb_ready;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic [REG_ADDR_WIDTH-1:0] wb_dest;

  modport slave (
    input  in_valid, in_result, in_flag, in_opcode, in_dest, wb_ready,
    output in_ready, wb_valid, wb_data, wb_dest
  );

  modport master (
    output in_valid, in_result, in_flag, in_opcode, in_dest, wb_ready,
    input  in_ready, wb_valid, wb_data, wb_dest
  );

endinterface

// File: rtl/alu_flag_reg.sv
// Architectural C/Z/N status flags; clear beats update, INC/DEC leave carry alone.
module alu_flag_reg
  import CPU_package::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_update,
  input  enum_alu_opcode_t      i_opcode,
  input  logic [DATA_WIDTH-1:0] i_result,
  input  logic                  i_carry,
  input  logic                  i_clr,
  output logic                  o_carry,
  output logic                  o_zero,
  output logic                  o_neg
);

  logic r_c;
  logic r_z;
  logic r_n;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c <= 1'b0;
      r_z <= 1'b0;
      r_n <= 1'b0;
    end else if (i_clr) begin
      r_c <= 1'b0;
      r_z <= 1'b0;
      r_n <= 1'b0;
    end else if (i_update && op_sets_flags(i_opcode)) begin
      if (!op_keeps_carry(i_opcode)) r_c <= i_carry;
      r_z <= (i_result == '0);
      r_n <= i_result[DATA_WIDTH-1];
    end
  end

  assign o_carry = r_c;
  assign o_zero  = r_z;
  assign o_neg   = r_n;

endmodule

// File: rtl/alu_result_stage.sv
// Two-entry result buffer between the arithmetic unit and register-file writeback,
// plus the C/Z/N flags whose carry feeds back into the next arithmetic operation.
module alu_result_stage
  import CPU_package::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  alu_result_stage_if.slave   bus,
  input  logic                flag_clr,
  output logic                carry_q,
  output logic                zero_q,
  output logic                neg_q
);

  if (DEPTH != 2) begin : g_bad_depth
    $error("alu_result_stage: DEPTH must be 2");
  end

  logic        w_push;
  logic        w_pop;
  logic        w_rptr_nxt;
  logic [1:0]  w_count_nxt;
  alu_result_t w_in_entry;
  alu_result_t w_head_nxt;
  logic        w_unused_flag_hi;

  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_count;
  logic        r_in_ready;
  logic        r_wb_valid;
  alu_result_t r_head;
  alu_result_t r_mem [DEPTH];

  assign w_in_entry       = '{data: bus.in_result, dest: bus.in_dest};
  assign w_unused_flag_hi = bus.in_flag[1];

  assign w_push = bus.in_valid & r_in_ready;
  assign w_pop  = r_wb_valid & bus.wb_ready;

  // The head register is loaded with whatever will sit at the read pointer after this
  // edge, bypassing the incoming entry when it lands directly in the head slot.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
    w_rptr_nxt = w_pop ? ~r_rptr : r_rptr;
    w_head_nxt = r_mem[w_rptr_nxt];
    if (w_push && (w_rptr_nxt == r_wptr)) w_head_nxt = w_in_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
      r_wb_valid <= 1'b0;
      r_head     <= '0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      r_rptr     <= w_rptr_nxt;
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != 2'd2);
      r_wb_valid <= (w_count_nxt != 2'd0);
      if (w_count_nxt != 2'd0) r_head <= w_head_nxt;
    end
  end

  // NOTE: storage is not reset; the pointers and count decide what is live, so stale
  // contents are never presented.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_in_entry;
  end

  assign bus.in_ready = r_in_ready;
  assign bus.wb_valid = r_wb_valid;
  assign bus.wb_data  = r_head.data;
  assign bus.wb_dest  = r_head.dest;

  alu_flag_reg u_flags (
    .clk      (clk),
    .rst      (rst),
    .i_update (w_push),
    .i_opcode (bus.in_opcode),
    .i_result (bus.in_result),
    .i_carry  (bus.in_flag[FLAG_C_BIT]),
    .i_clr    (flag_clr),
    .o_carry  (carry_q),
    .o_zero   (zero_q),
    .o_neg    (neg_q)
  );

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed scenarios plus randomized traffic against a queue-based model of the result stage.
module tb_alu_result_stage;
  import CPU_package::*;

  logic clk = 1'b0;
  logic rst;
  logic flag_clr;
  logic carry_q;
  logic zero_q;
  logic neg_q;

  alu_result_stage_if bus ();

  alu_result_stage #(.DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flag_clr (flag_clr),
    .carry_q  (carry_q),
    .zero_q   (zero_q),
    .neg_q    (neg_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [2:0] dest;
  } ent_t;

  ent_t       q[$];
  logic [7:0] m_data;
  logic [2:0] m_dest;
  logic       m_c, m_z, m_n;
  int         n_checks = 0;
  int         n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    check("wb_valid", 32'(bus.wb_valid), 32'(q.size() != 0));
    check("wb_data",  32'(bus.wb_data),  32'(m_data));
    check("wb_dest",  32'(bus.wb_dest),  32'(m_dest));
    check("carry_q",  32'(carry_q),      32'(m_c));
    check("zero_q",   32'(zero_q),       32'(m_z));
    check("neg_q",    32'(neg_q),        32'(m_n));
  endtask

  // Inputs are applied just after a falling edge; the model advances by one rising
  // edge and the DUT is compared at the following falling edge.
  task automatic step(input logic v, input logic [7:0] res, input logic [1:0] fl,
                      input enum_alu_opcode_t op, input logic [2:0] dst,
                      input logic wr, input logic clr, input logic rs);
    bit push;
    bit pop;
    bus.in_valid  = v;
    bus.in_result = res;
    bus.in_flag   = fl;
    bus.in_opcode = op;
    bus.in_dest   = dst;
    bus.wb_ready  = wr;
    flag_clr      = clr;
    rst           = rs;
    if (rs) begin
      q.delete();
      m_data = '0; m_dest = '0;
      m_c = 1'b0; m_z = 1'b0; m_n = 1'b0;
    end else begin
      push = v && (q.size() < 2);
      pop  = wr && (q.size() != 0);
      if (pop) q.delete(0);
      if (push) q.push_back('{res, dst});
      if (q.size() != 0) begin
        m_data = q[0].data;
        m_dest = q[0].dest;
      end
      if (clr) begin
        m_c = 1'b0; m_z = 1'b0; m_n = 1'b0;
      end else if (push && (op inside {ALU_ADD, ALU_SUB, ALU_INC, ALU_DEC, ALU_SHL, ALU_SHR})) begin
        if (!(op inside {ALU_INC, ALU_DEC})) m_c = fl[0];
        m_z = (res == 8'h00);
        m_n = res[7];
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input logic wr);
    step(1'b0, 8'h00, 2'b00, ALU_ADD, 3'd0, wr, 1'b0, 1'b0);
  endtask

  initial begin
    logic             v, wr, clr, rs;
    logic [7:0]       res;
    logic [1:0]       fl;
    logic [2:0]       dst;
    enum_alu_opcode_t op;

    rst = 1'b1; flag_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_result = '0; bus.in_flag = '0;
    bus.in_opcode = ALU_ADD; bus.in_dest = '0; bus.wb_ready = 1'b0;
    @(negedge clk);
    step(1'b0, 8'h00, 2'b00, ALU_ADD, 3'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 2'b00, ALU_ADD, 3'd0, 1'b0, 1'b0, 1'b1);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_wb_data",  32'(bus.wb_data),  32'd0);

    // ADD giving zero with carry out
    step(1'b1, 8'h00, 2'b01, ALU_ADD, 3'd3, 1'b0, 1'b0, 1'b0);
    check("add0_valid", 32'(bus.wb_valid), 32'd1);
    check("add0_data",  32'(bus.wb_data),  32'h00);
    check("add0_c",     32'(carry_q),      32'd1);
    check("add0_z",     32'(zero_q),       32'd1);
    check("add0_n",     32'(neg_q),        32'd0);
    idle(1'b1);

    // Fill to full with writeback stalled, then drain in order
    step(1'b1, 8'h11, 2'b00, ALU_ADD, 3'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 2'b00, ALU_ADD, 3'd2, 1'b0, 1'b0, 1'b0);
    check("full_ready", 32'(bus.in_ready), 32'd0);
    step(1'b1, 8'h33, 2'b00, ALU_ADD, 3'd3, 1'b0, 1'b0, 1'b0);
    check("held_head", 32'(bus.wb_data), 32'h11);
    step(1'b1, 8'h33, 2'b00, ALU_ADD, 3'd3, 1'b1, 1'b0, 1'b0);
    check("pop1_head", 32'(bus.wb_data), 32'h22);
    step(1'b1, 8'h33, 2'b00, ALU_ADD, 3'd3, 1'b1, 1'b0, 1'b0);
    check("pop2_head", 32'(bus.wb_data), 32'h33);
    idle(1'b1);
    check("empty_hold", 32'(bus.wb_data), 32'h33);

    // Simultaneous accept and pop with one entry buffered
    step(1'b1, 8'h55, 2'b00, ALU_ADD, 3'd5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h80, 2'b00, ALU_ADD, 3'd6, 1'b1, 1'b0, 1'b0);
    check("swap_data", 32'(bus.wb_data), 32'h80);
    check("swap_neg",  32'(neg_q),       32'd1);
    idle(1'b1);

    // INC keeps carry
    step(1'b0, 8'h00, 2'b00, ALU_ADD, 3'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h00, 2'b01, ALU_INC, 3'd1, 1'b1, 1'b0, 1'b0);
    check("inc_c", 32'(carry_q), 32'd0);
    check("inc_z", 32'(zero_q),  32'd1);

    // Clear wins over a coinciding SUB update
    step(1'b1, 8'hF0, 2'b01, ALU_SUB, 3'd2, 1'b1, 1'b1, 1'b0);
    check("clr_c",    32'(carry_q),  32'd0);
    check("clr_n",    32'(neg_q),    32'd0);
    check("clr_data", 32'(bus.wb_data), 32'hF0);
    idle(1'b1);

    // Reset with two entries buffered
    step(1'b1, 8'hA1, 2'b01, ALU_ADD, 3'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 2'b01, ALU_ADD, 3'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 2'b01, ALU_ADD, 3'd3, 1'b1, 1'b0, 1'b1);
    check("rst2_valid", 32'(bus.wb_valid), 32'd0);
    check("rst2_ready", 32'(bus.in_ready), 32'd1);
    check("rst2_c",     32'(carry_q),      32'd0);
    idle(1'b1);
    idle(1'b1);
    check("rst2_stale", 32'(bus.wb_valid), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      res = 8'($urandom);
      fl  = 2'($urandom);
      op  = enum_alu_opcode_t'(3'($urandom_range(0, 7)));
      dst = 3'($urandom);
      wr  = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 19) == 0);
      rs  = ($urandom_range(0, 199) == 0);
      step(v, res, fl, op, dst, wr, clr, rs);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
